// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core (m0) and a loader/debug port (m1).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking in IDLE; otherwise m0 always wins a tie.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX - 1);

    state_t     state;
    logic [7:0] idle_cnt;
    logic       rd_pending;
    logic       rd_owner;
    logic       tie_to_m1;
    logic       owner_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (m0_gnt) begin
            last_gnt <= 1'b0;
        end else if (m1_gnt) begin
            last_gnt <= 1'b1;
        end
    end

    assign tie_to_m1 = ~last_gnt;
`else
    assign tie_to_m1 = 1'b0;
`endif

    // Grants are combinational so an access issues in the same cycle it is requested.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        m0_gnt = ~tie_to_m1;
                        m1_gnt = tie_to_m1;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
                LOCK0:   m0_gnt = m0_req;
                LOCK1:   m1_gnt = m1_req;
                default: ;
            endcase
        end
    end

    assign mem_en    = m0_gnt | m1_gnt;
    assign mem_we    = m0_gnt ? m0_we : (m1_gnt ? m1_we : 1'b0);
    assign mem_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign owner_req = (state == LOCK0) ? m0_req : m1_req;

    // Lock ownership plus a watchdog that releases a lock whose owner has gone quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idle_cnt <= 8'd0;
        end else if (m0_gnt) begin
            state    <= m0_lock ? LOCK0 : IDLE;
            idle_cnt <= 8'd0;
        end else if (m1_gnt) begin
            state    <= m1_lock ? LOCK1 : IDLE;
            idle_cnt <= 8'd0;
        end else if (state != IDLE && !owner_req) begin
            if (idle_cnt == LOCK_LIMIT) begin
                state    <= IDLE;
                idle_cnt <= 8'd0;
            end else begin
                idle_cnt <= idle_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            rd_pending <= mem_en & ~mem_we;
            rd_owner   <= m1_gnt;
        end
    end

    assign m0_rvalid = rd_pending & ~rd_owner;
    assign m1_rvalid = rd_pending & rd_owner;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the core's load/store port (master 0) and a loader/debug port (master 1). It sits between the requesters and the memory. It grants at most one access per cycle and steers the one-cycle-latency read data back to the owner. It also supports a short bus lock for read-modify-write sequences, with a watchdog that breaks an abandoned lock.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LOCK_MAX, 16, maximum consecutive idle cycles a lock may be held with no request from its owner (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- m0_req / m1_req  in  1  access request, held until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_lock / m1_lock  in  1  keep ownership after this access
- m0_addr / m1_addr  in  ADDR_W  byte address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_gnt / m1_gnt  out  1  access accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid (registered)
- m0_rdata / m1_rdata  out  DATA_W  read data, meaningful only when rvalid=1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe

## Operation
- States: IDLE, LOCK0, LOCK1. Reset → IDLE.
- IDLE arbitration:
  - Only one requester: grant it.
  - Both requesting: priority per Configuration.
- LOCKk: only master k can be granted; the other master's request waits (gnt=0).
- Transfer: when mkgnt=1, set mem_en=1 and drive mem_we/addr/wdata from master k. When no grant, mem_en=0 and mem_we=0.
- Lock transitions:
  - Grant to k with mk_lock=1 → LOCKk.
  - Grant to k with mk_lock=0 → IDLE. This applies in both IDLE and LOCKk.
- Watchdog:
  - In LOCKk, an 8-bit counter counts cycles with mk_req=0.
  - The counter clears on entry to LOCKk and on any grant to k.
  - When it reaches LOCK_MAX-1 with mk_req still 0, next state is IDLE and the counter clears.
- Read return:
  - A granted read registers owner=k and a pending flag.
  - Next cycle: mk_rvalid=1 for one cycle and mk_rdata=mem_rdata. The other master's rdata is 0.
  - Writes produce no rvalid.
- Reset values: all gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, state IDLE, counter 0, last-grant pointer=1.

## Timing
- Grant latency 0 cycles: gnt is combinational from req and registered state.
- Read latency 1 cycle: rvalid is asserted the cycle after the grant.
- Back-to-back grants every cycle are allowed. rvalid for access N coincides with the grant of access N+1.
- Requester rules:
  - Hold req/we/addr/wdata/lock stable until gnt.
  - Dropping req before gnt is permitted: the request is withdrawn with no side effect.
- rst asserted mid-operation: outputs return to reset values immediately (asynchronous), and any pending rvalid is discarded.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On a simultaneous request in IDLE, grant the master not granted most recently (pointer register, updated on every grant).
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: master 0 always wins a tie.
  - The pointer register is omitted.

## Test plan
- Reset, then m0 read addr 0x10 with memory returning 0xDEADBEEF: m0_gnt=1 in the request cycle with mem_en=1, mem_we=0, mem_addr=0x10. Next cycle m0_rvalid=1 and m0_rdata=0xDEADBEEF, while m1_rvalid=0.
- m0 and m1 request continuously for 4 cycles:
  - Round-robin build: grants alternate 0,1,0,1.
  - Fixed-priority build: m0 is granted 4 times and m1_gnt stays 0.
- m1 read with lock=1 to 0x20, then m0 requests. m1 writes 0x21 to 0x20 with lock=0 two cycles later. Required: m0_gnt=0 until the m1 write is granted; m0 is granted the cycle after.
- m1 takes the lock and then drops req, with LOCK_MAX=4 and m0 requesting. Required: m0_gnt stays 0 for 4 cycles; state returns to IDLE; m0 is granted on cycle 5.
- m0 write 0x5 to 0x40 followed by m0 read of 0x40 in the next cycle. Required: no rvalid after the write; m0_rvalid=1 with data 0x5 one cycle after the read grant.
- Assert rst the cycle after a granted read. Required: m0_rvalid stays 0, state is IDLE, and the first post-reset tie goes to m0.
